// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - decode_t package and decode-queue / issue-lane interface
package issue_scheduler_pkg;
  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_CTRL} op_e;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wr_en;
    logic        use_pc;
    logic        use_imm;
    logic [15:0] imm;
  } decode_t;
endpackage

interface issue_scheduler_if #(parameter int ISSUE_W = 2) ();
  import issue_scheduler_pkg::*;
  localparam int TW = $clog2(ISSUE_W + 1);

  logic    [ISSUE_W-1:0] i_dque_valid;
  decode_t [ISSUE_W-1:0] i_dque_decode;
  logic    [TW-1:0]      o_sch_dque_take;
  decode_t [ISSUE_W-1:0] o_sch_decode;
  logic    [TW-1:0]      o_sch_issue_cnt;

  modport master (
    input  i_dque_valid, i_dque_decode,
    output o_sch_dque_take, o_sch_decode, o_sch_issue_cnt
  );

  modport slave (
    output i_dque_valid, i_dque_decode,
    input  o_sch_dque_take, o_sch_decode, o_sch_issue_cnt
  );
endinterface

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - N-wide in-order issue scheduler with pending FIFO
// Define SCHED_WAW_CHECK_EN to also split groups on same-rd writers.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int ISSUE_W   = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_flush,
  input  logic                i_exe_hold,
  issue_scheduler_if.master   dq
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int TW = $clog2(ISSUE_W + 1);

  decode_t               mem [BUF_DEPTH];
  logic    [PW-1:0]      rd_ptr, wr_ptr;
  logic    [CW-1:0]      count;
  decode_t [ISSUE_W-1:0] lane_q;
  logic    [TW-1:0]      issue_cnt_q;

  decode_t [ISSUE_W-1:0] head;
  decode_t [ISSUE_W-1:0] grp_lane;
  logic    [TW-1:0]      grp_n, nvalid, take;
  logic    [CW-1:0]      pop, space;
  logic                  lu_valid, hazard, stop, mem_seen;
  logic    [4:0]         lu_rd;

  function automatic logic reads_reg(decode_t d, logic [4:0] r);
    return (r != 5'd0) && ((!d.use_pc && d.rs1 == r) || (!d.use_imm && d.rs2 == r));
  endfunction

  function automatic logic is_mem(decode_t d);
    return (d.op == OP_LOAD) || (d.op == OP_STORE);
  endfunction

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      head[k] = mem[rd_ptr + PW'(k)];
    end
  end

  // The group currently on the lanes is what execute sees next; its load result is not yet forwardable.
  always_comb begin
    lu_valid = 1'b0;
    lu_rd    = 5'd0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (lane_q[k].valid && lane_q[k].op == OP_LOAD && lane_q[k].rd != 5'd0) begin
        lu_valid = 1'b1;
        lu_rd    = lane_q[k].rd;
      end
    end
  end

  // A control transfer ends the group, so at most one can ever join.
  always_comb begin
    grp_n    = '0;
    stop     = 1'b0;
    mem_seen = 1'b0;
    hazard   = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      hazard = (CW'(k) >= count) || (lu_valid && reads_reg(head[k], lu_rd));
      if (is_mem(head[k]) && mem_seen) hazard = 1'b1;
      for (int j = 0; j < ISSUE_W; j++) begin
        if (j < k) begin
          if (head[j].wr_en && reads_reg(head[k], head[j].rd)) hazard = 1'b1;
`ifdef SCHED_WAW_CHECK_EN
          if (head[j].wr_en && head[k].wr_en && head[j].rd != 5'd0 && head[j].rd == head[k].rd)
            hazard = 1'b1;
`endif
        end
      end
      if (stop || hazard) begin
        stop = 1'b1;
      end else begin
        grp_n = TW'(k + 1);
        if (is_mem(head[k])) mem_seen = 1'b1;
        if (head[k].op == OP_CTRL) stop = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      grp_lane[k]       = head[k];
      grp_lane[k].valid = 1'b1;
      if (TW'(k) >= grp_n) grp_lane[k] = '0;
    end
  end

  // Space counts entries freed by this cycle's issue; the data itself is not bypassed.
  always_comb begin
    nvalid = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (dq.i_dque_valid[k]) nvalid = nvalid + TW'(1);
    end
    pop   = (i_flush || i_exe_hold) ? '0 : CW'(grp_n);
    space = CW'(BUF_DEPTH) - (count - pop);
    if (!i_rstn || i_flush)     take = '0;
    else if (CW'(nvalid) < space) take = nvalid;
    else                        take = TW'(space);
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < ISSUE_W; k++) begin
      if (TW'(k) < take) mem[wr_ptr + PW'(k)] <= dq.i_dque_decode[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      lane_q      <= '0;
      issue_cnt_q <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(take);
      count  <= count - pop + CW'(take);
      if (!i_exe_hold) begin
        lane_q      <= grp_lane;
        issue_cnt_q <= grp_n;
      end
    end
  end

  assign dq.o_sch_dque_take = take;
  assign dq.o_sch_decode    = lane_q;
  assign dq.o_sch_issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - directed and random checks of issue_scheduler against a queue model
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;
  localparam int W = 2;
  localparam int D = 4;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic i_flush = 1'b0;
  logic i_exe_hold = 1'b0;

  issue_scheduler_if #(.ISSUE_W(W)) dq ();

  issue_scheduler #(.ISSUE_W(W), .BUF_DEPTH(D)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_flush    (i_flush),
    .i_exe_hold (i_exe_hold),
    .dq         (dq)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int obs_take = 0;
  int next_tag = 100;

  decode_t src[$];
  decode_t q[$];
  decode_t exp_lane[W];
  int      exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decode_t mk(input op_e op, input int rd, input int rs1, input int rs2,
                                 input bit wr, input bit ui, input int tag);
    decode_t d;
    d = '0;
    d.valid = 1'b1;
    d.op = op;
    d.rd = 5'(rd);
    d.rs1 = 5'(rs1);
    d.rs2 = 5'(rs2);
    d.wr_en = wr;
    d.use_imm = ui;
    d.imm = 16'(tag);
    return d;
  endfunction

  function automatic decode_t rnd_instr();
    decode_t d;
    d = '0;
    d.valid = 1'b1;
    d.op = op_e'($urandom_range(0, 3));
    d.rd = 5'($urandom_range(0, 7));
    d.rs1 = 5'($urandom_range(0, 7));
    d.rs2 = 5'($urandom_range(0, 7));
    d.use_pc = ($urandom_range(0, 3) == 0);
    d.use_imm = ($urandom_range(0, 2) == 0);
    d.wr_en = (d.op == OP_STORE) ? 1'b0 : (d.op == OP_CTRL) ? 1'($urandom_range(0, 1)) : 1'b1;
    d.imm = 16'(next_tag);
    next_tag++;
    return d;
  endfunction

  function automatic bit reads(input decode_t d, input logic [4:0] r);
    return (r != 0) && ((!d.use_pc && d.rs1 == r) || (!d.use_imm && d.rs2 == r));
  endfunction

  // Longest in-order prefix of the pending queue that obeys the issue rules.
  function automatic int model_group();
    int n = 0;
    bit mem_used = 0;
    logic [4:0] lu = 0;
    decode_t d;
    bit blocked;
    for (int k = 0; k < W; k++)
      if (exp_lane[k].valid && exp_lane[k].op == OP_LOAD) lu = exp_lane[k].rd;
    for (int i = 0; i < W && i < q.size(); i++) begin
      d = q[i];
      blocked = reads(d, lu);
      for (int j = 0; j < i; j++) begin
        if (q[j].wr_en && reads(d, q[j].rd)) blocked = 1;
`ifdef SCHED_WAW_CHECK_EN
        if (q[j].wr_en && d.wr_en && q[j].rd != 0 && q[j].rd == d.rd) blocked = 1;
`endif
      end
      if ((d.op == OP_LOAD || d.op == OP_STORE) && mem_used) blocked = 1;
      if (blocked) break;
      n++;
      if (d.op == OP_LOAD || d.op == OP_STORE) mem_used = 1;
      if (d.op == OP_CTRL) break;
    end
    return n;
  endfunction

  task automatic tick();
    int nv, n, pop, exp_take;
    nv = (src.size() < W) ? src.size() : W;
    for (int k = 0; k < W; k++) begin
      dq.i_dque_valid[k] = (k < nv);
      dq.i_dque_decode[k] = (k < nv) ? src[k] : '0;
    end
    #1;
    n = model_group();
    pop = i_exe_hold ? 0 : n;
    exp_take = D - (q.size() - pop);
    if (nv < exp_take) exp_take = nv;
    if (!i_rstn || i_flush) exp_take = 0;
    obs_take = int'(dq.o_sch_dque_take);
    chk("take", 64'(dq.o_sch_dque_take), 64'(exp_take));
    @(posedge i_clk);
    if (!i_rstn || i_flush) begin
      q.delete();
      for (int k = 0; k < W; k++) exp_lane[k] = '0;
      exp_cnt = 0;
    end else begin
      if (!i_exe_hold) begin
        for (int k = 0; k < W; k++) begin
          exp_lane[k] = (k < n) ? q[k] : '0;
          if (k < n) exp_lane[k].valid = 1'b1;
        end
        repeat (n) void'(q.pop_front());
        exp_cnt = n;
      end
      for (int k = 0; k < exp_take; k++) q.push_back(src[k]);
      repeat (exp_take) void'(src.pop_front());
    end
    @(negedge i_clk);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("lane%0d_valid", k), 64'(dq.o_sch_decode[k].valid), 64'(exp_lane[k].valid));
      if (exp_lane[k].valid)
        chk($sformatf("lane%0d_data", k), 64'(dq.o_sch_decode[k]), 64'(exp_lane[k]));
    end
    chk("issue_cnt", 64'(dq.o_sch_issue_cnt), 64'(exp_cnt));
  endtask

  initial begin
    for (int k = 0; k < W; k++) exp_lane[k] = '0;
    dq.i_dque_valid = '0;
    dq.i_dque_decode = '0;
    @(negedge i_clk);

    // reset with valid input presented
    src.push_back(mk(OP_ALU, 1, 2, 3, 1, 0, 1));
    src.push_back(mk(OP_ALU, 4, 5, 6, 1, 0, 2));
    repeat (3) begin
      tick();
      chk("rst_take", 64'(obs_take), 64'd0);
    end
    chk("rst_lane0", 64'(dq.o_sch_decode[0]), 64'd0);
    chk("rst_lane1", 64'(dq.o_sch_decode[1]), 64'd0);
    chk("rst_cnt", 64'(dq.o_sch_issue_cnt), 64'd0);
    i_rstn = 1'b1;

    // independent pair co-issues
    tick();
    chk("indep_take", 64'(obs_take), 64'd2);
    tick();
    chk("indep_cnt", 64'(dq.o_sch_issue_cnt), 64'd2);
    chk("indep_l1", 64'(dq.o_sch_decode[1].imm), 64'd2);

    // RAW splits the pair
    src.push_back(mk(OP_ALU, 1, 2, 3, 1, 0, 3));
    src.push_back(mk(OP_ALU, 7, 1, 4, 1, 0, 4));
    tick();
    tick();
    chk("raw_cnt0", 64'(dq.o_sch_issue_cnt), 64'd1);
    chk("raw_l0a", 64'(dq.o_sch_decode[0].imm), 64'd3);
    tick();
    chk("raw_l0b", 64'(dq.o_sch_decode[0].imm), 64'd4);

    // load-use bubble
    src.push_back(mk(OP_LOAD, 5, 2, 0, 1, 1, 5));
    src.push_back(mk(OP_ALU, 6, 5, 1, 1, 0, 6));
    tick();
    tick();
    chk("lu_load", 64'(dq.o_sch_decode[0].imm), 64'd5);
    tick();
    chk("lu_bubble_cnt", 64'(dq.o_sch_issue_cnt), 64'd0);
    chk("lu_bubble_v", 64'(dq.o_sch_decode[0].valid), 64'd0);
    tick();
    chk("lu_add", 64'(dq.o_sch_decode[0].imm), 64'd6);

    // hold fills the FIFO, release drains in order
    i_exe_hold = 1'b1;
    for (int t = 7; t <= 12; t++) src.push_back(mk(OP_ALU, t, 20, 21, 1, 0, t));
    tick();
    chk("hold_take0", 64'(obs_take), 64'd2);
    tick();
    chk("hold_take1", 64'(obs_take), 64'd2);
    tick();
    chk("hold_take2", 64'(obs_take), 64'd0);
    chk("hold_lane", 64'(dq.o_sch_decode[0].imm), 64'd6);
    i_exe_hold = 1'b0;
    tick();
    chk("rel_g0", 64'({dq.o_sch_decode[0].imm, dq.o_sch_decode[1].imm}), {32'd0, 16'd7, 16'd8});
    tick();
    chk("rel_g1", 64'({dq.o_sch_decode[0].imm, dq.o_sch_decode[1].imm}), {32'd0, 16'd9, 16'd10});
    repeat (4) tick();

    // flush with hold and three pending entries
    i_exe_hold = 1'b1;
    for (int t = 20; t <= 22; t++) src.push_back(mk(OP_ALU, t - 10, 20, 21, 1, 0, t));
    tick();
    tick();
    i_flush = 1'b1;
    tick();
    chk("flush_take", 64'(obs_take), 64'd0);
    chk("flush_cnt", 64'(dq.o_sch_issue_cnt), 64'd0);
    chk("flush_v0", 64'(dq.o_sch_decode[0].valid), 64'd0);
    i_flush = 1'b0;
    i_exe_hold = 1'b0;
    tick();
    chk("flush_empty", 64'(dq.o_sch_issue_cnt), 64'd0);

    // one memory op per group
    src.push_back(mk(OP_LOAD, 1, 2, 0, 1, 1, 30));
    src.push_back(mk(OP_STORE, 0, 4, 3, 0, 0, 31));
    tick();
    tick();
    chk("mem_lw", 64'({dq.o_sch_issue_cnt, dq.o_sch_decode[0].imm}), {46'd1, 16'd30});
    tick();
    chk("mem_sw", 64'({dq.o_sch_issue_cnt, dq.o_sch_decode[0].imm}), {46'd1, 16'd31});

    // same destination register
    src.push_back(mk(OP_ALU, 1, 2, 3, 1, 0, 32));
    src.push_back(mk(OP_ALU, 1, 5, 0, 1, 1, 33));
    tick();
    tick();
`ifdef SCHED_WAW_CHECK_EN
    chk("waw_cnt", 64'(dq.o_sch_issue_cnt), 64'd1);
    tick();
    chk("waw_second", 64'(dq.o_sch_decode[0].imm), 64'd33);
`else
    chk("waw_cnt", 64'(dq.o_sch_issue_cnt), 64'd2);
    chk("waw_second", 64'(dq.o_sch_decode[1].imm), 64'd33);
    tick();
`endif

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      while (src.size() < 6 && $urandom_range(0, 3) != 0) src.push_back(rnd_instr());
      i_exe_hold = ($urandom_range(0, 4) == 0);
      i_flush = ($urandom_range(0, 29) == 0);
      i_rstn = ($urandom_range(0, 99) != 0);
      tick();
    end
    i_rstn = 1'b1;
    i_flush = 1'b0;
    i_exe_hold = 1'b0;
    repeat (12) tick();
    chk("drain_q", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
